// File: rtl/ariane_pkg.sv
// ariane_pkg: return-address protection constants and exception type shared with branch_unit
package ariane_pkg;
    localparam logic [30:0] RA_XOR_KEY  = 31'h73fa06c2;
    localparam logic [63:0] RA_MISMATCH = 64'd24;
    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;
    typedef enum logic {RUN, FAULT} ra_state_e;
    function automatic logic [31:0] ra_expected(input logic [31:0] entry, input logic [30:0] key);
        return {1'b0, entry[31] ? entry[30:0] ^ key : entry[30:0]};
    endfunction
endpackage

// File: rtl/ra_shadow_stack.sv
// ra_shadow_stack: circular link stack, oldest entry overwritten when full
module ra_shadow_stack #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [31:0]              data_i,
    output logic [31:0]              top_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     pop_ok_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] ptr_q;
    logic [CW-1:0] count_q;
    logic          full;
    logic [AW-1:0] wr_ptr;
    assign pop_ok_o = pop_i && count_q != '0;
    assign full     = count_q == CW'(DEPTH);
    assign top_o    = mem[ptr_q];
    assign count_o  = count_q;
    // a simultaneous pop frees the top slot, so the new link replaces it in place
    assign wr_ptr   = pop_ok_o ? ptr_q : ptr_q + 1'b1;
    // bit 31 is kept so non-encoded links can later be compared raw
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem[wr_ptr] <= data_i;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            count_q     <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= !flush_i && push_i && !pop_ok_o && full;
            underflow_o <= !flush_i && pop_i && count_q == '0;
            if (flush_i) begin
                ptr_q   <= '0;
                count_q <= '0;
            end else if (push_i && !pop_ok_o) begin
                ptr_q   <= ptr_q + 1'b1;
                count_q <= full ? count_q : count_q + 1'b1;
            end else if (pop_ok_o && !push_i) begin
                ptr_q   <= ptr_q - 1'b1;
                count_q <= count_q - 1'b1;
            end
        end
    end
endmodule

// File: rtl/ra_return_checker.sv
// ra_return_checker: XOR-keyed return-address check against a shadow stack with sticky fault FSM
module ra_return_checker
    import ariane_pkg::*;
#(
    parameter int          DEPTH   = 8,
    parameter logic [30:0] KEY_RST = RA_XOR_KEY
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   call_valid_i,
    input  logic [31:0]            call_link_i,
    input  logic                   ret_valid_i,
    input  logic [31:0]            ret_target_i,
    input  logic                   key_we_i,
    input  logic [30:0]            key_i,
    input  logic                   lock_i,
    input  logic                   fault_ack_i,
    output logic [30:0]            key_o,
    output exception_t             fault_o,
    output logic                   underflow_o,
    output logic                   overflow_o,
    output logic [$clog2(DEPTH):0] depth_o
);
    ra_state_e   state_q, state_d;
    logic [30:0] key_q;
    logic        lock_q;
    logic [31:0] tval_q, tval_d;
    logic [31:0] top;
    logic        pop_ok;
    logic        mismatch;
    logic        load;
    ra_shadow_stack #(.DEPTH(DEPTH)) u_stack (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (call_valid_i),
        .pop_i       (ret_valid_i),
        .data_i      (call_link_i),
        .top_o       (top),
        .count_o     (depth_o),
        .pop_ok_o    (pop_ok),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );
    assign mismatch = ret_valid_i && !flush_i && pop_ok && ret_target_i != ra_expected(top, key_q);
    // while faulted, only an ack coinciding with a new mismatch may replace tval
    always_comb begin
        load    = mismatch && (state_q == RUN || fault_ack_i);
        state_d = load ? FAULT : fault_ack_i ? RUN : state_q;
        tval_d  = load ? ret_target_i : tval_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            tval_q  <= '0;
            key_q   <= KEY_RST;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tval_q  <= tval_d;
            key_q   <= key_we_i && !lock_q ? key_i : key_q;
            lock_q  <= lock_q | lock_i;
        end
    end
    assign key_o   = key_q;
    assign fault_o = '{cause: RA_MISMATCH, tval: {32'b0, tval_q}, valid: state_q == FAULT};
endmodule
